// File: rtl/alu_muldiv_if.sv
// ALU / multiply-divide bundle between the execute datapath and alu_muldiv.
// The master drives operands and md requests; the slave returns results.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             md_start;
  logic [1:0]       md_op;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output operation, a, b, md_start, md_op,
    input  result, zero, md_busy, md_done, hi, lo
  );

  modport slave (
    input  operation, a, b, md_start, md_op,
    output result, zero, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with an iterative 32-step multiply/divide unit.
// HI/LO are written once per operation, in the FIX state.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_muldiv_if.slave  io
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FIX, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sgn;
  logic [WIDTH-1:0] ax, bx;
  logic [WIDTH:0]   msum, rsh, rdif;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] res;

  always_comb begin
    res = '0;
    case (io.operation)
      4'b0010: res = io.a + io.b;
      4'b0110: res = io.a - io.b;
      4'b0000: res = io.a & io.b;
      4'b0001: res = io.a | io.b;
      4'b0111: res = {{(WIDTH-1){1'b0}},
                      $signed(io.a) < $signed(io.b)};
      4'b1100: res = ~(io.a | io.b);
      default: res = '0;
    endcase
  end

  assign io.result  = res;
  assign io.zero    = (res == '0);
  assign io.md_busy = busy_q;
  assign io.md_done = done_q;
  assign io.hi      = hi_q;
  assign io.lo      = lo_q;

  // Signed ops run on magnitudes; signs are reapplied in FIX.
  assign sgn = ~io.md_op[0];
  assign ax  = (sgn && io.a[WIDTH-1]) ? -io.a : io.a;
  assign bx  = (sgn && io.b[WIDTH-1]) ? -io.b : io.b;

  assign msum = {1'b0, acc_q[W2-1:WIDTH]}
              + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign rsh  = acc_q[W2-1:WIDTH-1];
  assign rdif = rsh - {1'b0, dvs_q};

  assign prod = nq_q ? -acc_q : acc_q;
  assign quo  = nq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = nr_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    dz_d    = dz_q;
    araw_d  = araw_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (io.md_start) begin
          div_d   = io.md_op[1];
          nq_d    = sgn && (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
          nr_d    = sgn && io.a[WIDTH-1];
          dz_d    = (io.b == '0);
          araw_d  = io.a;
          dvs_d   = bx;
          acc_d   = {{WIDTH{1'b0}}, ax};
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!div_q)
          acc_d = {msum, acc_q[WIDTH-1:1]};
        else if (rdif[WIDTH])
          acc_d = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
          acc_d = {rdif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (!div_q) begin
          {hi_d, lo_d} = prod;
        end else if (dz_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      dz_q    <= 1'b0;
      araw_q  <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      dz_q    <= dz_d;
      araw_q  <= araw_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv against a plain
// arithmetic reference model (64-bit products, signed / and %).
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  alu_muldiv_if #(.WIDTH(32)) io ();

  alu_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (op)
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b1100: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  // Returns {hi, lo}.
  function automatic logic [63:0] md_ref(input logic [1:0] op,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, v, w;
    sx = longint'(int'(x));
    sy = longint'(int'(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    if (op[1] && y == 32'd0)
      return {x, 32'hFFFF_FFFF};
    case (op)
      2'b00: begin
        v = 64'(sx * sy);
        return v;
      end
      2'b01: return ux * uy;
      2'b10: begin
        q = sx / sy;
        r = sx % sy;
        v = 64'(q);
        w = 64'(r);
        return {w[31:0], v[31:0]};
      end
      default: begin
        v = ux / uy;
        w = ux % uy;
        return {w[31:0], v[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic alu_vec(input string tag, input logic [3:0] op,
                         input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    io.operation = op;
    io.a = x;
    io.b = y;
    #1;
    r = alu_ref(op, x, y);
    chk({tag, ".res"}, {32'b0, io.result}, {32'b0, r});
    chk({tag, ".zero"}, {63'b0, io.zero}, {63'b0, r == 32'd0});
  endtask

  task automatic md_run(input string tag, input logic [1:0] op,
                        input logic [31:0] x, input logic [31:0] y,
                        input bit poke);
    logic [63:0] r;
    int busy_cnt, done_at, ndone;
    busy_cnt = 0;
    done_at = 0;
    ndone = 0;
    r = md_ref(op, x, y);
    @(negedge clk);
    io.md_start = 1'b1;
    io.md_op = op;
    io.a = x;
    io.b = y;
    @(negedge clk);
    io.md_start = 1'b0;
    io.a = $urandom;
    io.b = $urandom;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (io.md_busy) busy_cnt++;
      if (io.md_done) begin
        ndone++;
        if (done_at == 0) done_at = i;
      end
      if (i == 20)
        chk({tag, ".hold"}, {io.hi, io.lo}, {exp_hi, exp_lo});
      if (poke && i == 5) begin
        io.md_start = 1'b1;
        io.md_op = 2'($urandom);
        io.a = $urandom;
        io.b = $urandom;
      end
      if (poke && i == 6) io.md_start = 1'b0;
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk({tag, ".busy"}, 64'(busy_cnt), 64'd33);
    chk({tag, ".done_at"}, 64'(done_at), 64'd34);
    chk({tag, ".ndone"}, 64'(ndone), 64'd1);
    chk({tag, ".hi"}, {32'b0, io.hi}, {32'b0, exp_hi});
    chk({tag, ".lo"}, {32'b0, io.lo}, {32'b0, exp_lo});
  endtask

  initial begin
    int ndone;
    logic [3:0] ops [8];
    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
            4'b0111, 4'b1100, 4'b0101, 4'b1111};
    rst_n = 1'b0;
    io.operation = '0;
    io.a = '0;
    io.b = '0;
    io.md_start = 1'b0;
    io.md_op = '0;
    repeat (3) @(negedge clk);
    chk("rst.hi", {32'b0, io.hi}, 64'd0);
    chk("rst.lo", {32'b0, io.lo}, 64'd0);
    chk("rst.busy", {63'b0, io.md_busy}, 64'd0);
    chk("rst.done", {63'b0, io.md_done}, 64'd0);
    rst_n = 1'b1;

    alu_vec("add", 4'b0010, 32'h7FFF_FFFF, 32'd1);
    chk("add.val", {32'b0, io.result}, 64'h8000_0000);
    alu_vec("sub", 4'b0110, 32'h7FFF_FFFF, 32'd1);
    chk("sub.val", {32'b0, io.result}, 64'h7FFF_FFFE);
    alu_vec("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1);
    chk("slt.val", {32'b0, io.result}, 64'd1);
    alu_vec("nor", 4'b1100, 32'd0, 32'd0);
    chk("nor.val", {32'b0, io.result}, 64'hFFFF_FFFF);
    alu_vec("bad", 4'b0101, 32'h7FFF_FFFF, 32'd1);
    chk("bad.zero", {63'b0, io.zero}, 64'd1);

    md_run("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu.k", {io.hi, io.lo}, 64'hFFFF_FFFE_0000_0001);
    md_run("mult", 2'b00, -32'sd3, 32'd5, 1'b0);
    chk("mult.k", {io.hi, io.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    md_run("div", 2'b10, -32'sd7, 32'd2, 1'b0);
    chk("div.k", {io.hi, io.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    md_run("divu", 2'b11, 32'd7, 32'd2, 1'b0);
    chk("divu.k", {io.hi, io.lo}, 64'h0000_0001_0000_0003);
    md_run("divmin", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divmin.k", {io.hi, io.lo}, 64'h0000_0000_8000_0000);
    md_run("dz", 2'b11, 32'h1234, 32'd0, 1'b0);
    chk("dz.k", {io.hi, io.lo}, 64'h0000_1234_FFFF_FFFF);
    md_run("poke", 2'b00, 32'd1000, -32'sd77, 1'b1);

    // Abort in RUN: no write, no done pulse afterwards.
    @(negedge clk);
    io.md_start = 1'b1;
    io.md_op = 2'b01;
    io.a = 32'hDEAD_BEEF;
    io.b = 32'h1234_5678;
    @(negedge clk);
    io.md_start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    chk("abort.busy", {63'b0, io.md_busy}, 64'd0);
    chk("abort.hilo", {io.hi, io.lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.md_done) ndone++;
    end
    chk("abort.nodone", 64'(ndone), 64'd0);

    // Start together with reset: reset wins.
    rst_n = 1'b0;
    io.md_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    io.md_start = 1'b0;
    chk("rstwin.busy0", {63'b0, io.md_busy}, 64'd0);
    @(negedge clk);
    chk("rstwin.busy1", {63'b0, io.md_busy}, 64'd0);

    for (int i = 0; i < 14; i++)
      md_run("rnd", 2'($urandom), pick(), pick(), i[0]);

    for (int i = 0; i < 200; i++)
      alu_vec("alu_rnd", ops[$urandom_range(0, 7)], pick(), pick());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
